// File: rtl/fb_swap_ctrl.sv
// Frame sequencer for a double-buffered framebuffer pair: clear back, render, wait vsync, swap.
// Optional statistics outputs are compiled in with `define FB_SWAP_STATS_EN.
module fb_swap_ctrl #(
  parameter int FB_WIDTH      = 160,
  parameter int FB_HEIGHT     = 120,
  parameter int CLEAR_TIMEOUT = FB_WIDTH*FB_HEIGHT+8
`ifdef FB_SWAP_STATS_EN
  ,
  parameter int CNT_WIDTH     = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic frame_start,
  input  logic render_done,
  input  logic fb0_clearing,
  input  logic fb1_clearing,
  output logic fb0_clear,
  output logic fb1_clear,
  output logic render_start,
  output logic back_sel,
  output logic swap,
  output logic busy,
  output logic clear_err
`ifdef FB_SWAP_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] frames_out,
  output logic [CNT_WIDTH-1:0] dropped_out,
  output logic [CNT_WIDTH-1:0] render_cycles_out
`endif
);

  // state      | meaning
  // IDLE       | parked, waiting for enable
  // CLEAR      | clearing the back buffer (fbN, N = back_sel)
  // RENDER     | rasterizer drawing into the back buffer
  // WAIT_VSYNC | render finished, holding for the next frame_start
  // SWAP       | one cycle: swap pulse, back_sel flips at its end
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    RENDER     = 3'd2,
    WAIT_VSYNC = 3'd3,
    SWAP       = 3'd4
  } state_t;

  localparam int TO_W = $clog2(CLEAR_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(CLEAR_TIMEOUT - 1);

  state_t          state, state_nxt;
  logic            seen_clearing;
  logic [TO_W-1:0] clr_cnt;
  logic            in_clear;
  logic            back_clearing;
  logic            clear_done;
  logic            clear_to;
  logic            clear_req;

  assign in_clear      = (state == CLEAR);
  assign back_clearing = back_sel ? fb1_clearing : fb0_clearing;
  assign clear_done    = in_clear && seen_clearing && !back_clearing;
  // Timeout fires on the CLEAR_TIMEOUT-th CLEAR cycle; a genuine completion wins a tie.
  assign clear_to      = in_clear && !clear_done && (clr_cnt == TO_LAST);
  // Gated in the completion cycle so the buffer never starts a second clear pass.
  assign clear_req     = in_clear && !clear_done && !clear_to;

  assign fb0_clear = clear_req && !back_sel;
  assign fb1_clear = clear_req &&  back_sel;
  assign swap      = (state == SWAP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (enable) state_nxt = CLEAR;
      CLEAR:      if (clear_done || clear_to) state_nxt = RENDER;
      RENDER:     if (render_done) state_nxt = frame_start ? SWAP : WAIT_VSYNC;
      WAIT_VSYNC: if (frame_start) state_nxt = SWAP;
      SWAP:       state_nxt = enable ? CLEAR : IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      back_sel      <= 1'b0;
      seen_clearing <= 1'b0;
      clr_cnt       <= '0;
      clear_err     <= 1'b0;
      render_start  <= 1'b0;
    end else begin
      state        <= state_nxt;
      render_start <= in_clear && (state_nxt == RENDER);
      if (state == SWAP) back_sel <= ~back_sel;
      if (in_clear && (state_nxt == CLEAR)) begin
        if (back_clearing) seen_clearing <= 1'b1;
        clr_cnt <= clr_cnt + TO_W'(1);
      end else begin
        seen_clearing <= 1'b0;
        clr_cnt       <= '0;
      end
      if (clear_to) clear_err <= 1'b1;
    end
  end

`ifdef FB_SWAP_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  logic [CNT_WIDTH-1:0] render_cnt;
  logic                 dropped_evt;

  assign dropped_evt = frame_start && !render_done && (in_clear || (state == RENDER));

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_out        <= '0;
      dropped_out       <= '0;
      render_cycles_out <= '0;
      render_cnt        <= '0;
    end else begin
      if (swap && (frames_out != CNT_MAX)) frames_out <= frames_out + CNT_WIDTH'(1);
      if (dropped_evt && (dropped_out != CNT_MAX)) dropped_out <= dropped_out + CNT_WIDTH'(1);
      if (state == SWAP) begin
        render_cycles_out <= render_cnt;
        render_cnt        <= '0;
      end else if ((state == RENDER) && (render_cnt != CNT_MAX)) begin
        render_cnt <= render_cnt + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Scoreboard bench for fb_swap_ctrl: frame-level plan predicts pulse timing and clear/busy windows.
module tb_fb_swap_ctrl;
  localparam int FB_W = 8;
  localparam int FB_H = 4;
  localparam int T    = FB_W*FB_H + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, frame_start = 1'b0, render_done = 1'b0;
  logic fb0_clearing, fb1_clearing;
  logic fb0_clear, fb1_clear, render_start, back_sel, swap, busy, clear_err;
`ifdef FB_SWAP_STATS_EN
  logic [15:0] frames_out, dropped_out, render_cycles_out;
`endif

  always #5 clk = ~clk;

  fb_swap_ctrl #(.FB_WIDTH(FB_W), .FB_HEIGHT(FB_H)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .render_done(render_done), .fb0_clearing(fb0_clearing), .fb1_clearing(fb1_clearing),
    .fb0_clear(fb0_clear), .fb1_clear(fb1_clear), .render_start(render_start),
    .back_sel(back_sel), .swap(swap), .busy(busy), .clear_err(clear_err)
`ifdef FB_SWAP_STATS_EN
    , .frames_out(frames_out), .dropped_out(dropped_out), .render_cycles_out(render_cycles_out)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer model: a clear request starts a pass of cl_len cycles of clearing.
  int rem [2] = '{0, 0};
  int cl_len [2] = '{32, 32};
  bit never_clr [2] = '{1'b0, 1'b0};
  always @(posedge clk) begin
    if (rem[0] != 0) rem[0] <= rem[0] - 1;
    else if (fb0_clear === 1'b1 && !never_clr[0]) rem[0] <= cl_len[0];
    if (rem[1] != 0) rem[1] <= rem[1] - 1;
    else if (fb1_clear === 1'b1 && !never_clr[1]) rem[1] <= cl_len[1];
  end
  assign fb0_clearing = (rem[0] != 0);
  assign fb1_clearing = (rem[1] != 0);

  typedef struct { bit kind; int at; bit bs; } ev_t;
  ev_t evq[$];
  bit [1:0] exp_clr [int];
  bit       exp_busy [int];
  int n_cmp = 0, n_bad = 0;
  int err_from = -1, err_until = 32'h3fff_ffff;
  bit m_bs = 1'b0;
  int next_e = 0;

  always @(negedge clk) begin : monitor
    bit [1:0] ec;
    bit eb, ee;
    ev_t e;
    if (cyc >= 1) begin
      ec = exp_clr.exists(cyc) ? exp_clr[cyc] : 2'b00;
      eb = exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0;
      ee = (err_from >= 0) && (cyc >= err_from) && (cyc < err_until);
      n_cmp++;
      if ({fb1_clear, fb0_clear} !== ec) begin
        n_bad++; $display("FAIL clear cyc=%0d got=%b exp=%b", cyc, {fb1_clear, fb0_clear}, ec);
      end
      n_cmp++;
      if (busy !== eb) begin
        n_bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
      end
      n_cmp++;
      if (clear_err !== ee) begin
        n_bad++; $display("FAIL clear_err cyc=%0d got=%b exp=%b", cyc, clear_err, ee);
      end
      if (render_start === 1'b1 || swap === 1'b1) begin
        n_cmp++;
        if (evq.size() == 0) begin
          n_bad++; $display("FAIL event cyc=%0d unexpected rs=%b swap=%b", cyc, render_start, swap);
        end else begin
          e = evq.pop_front();
          if (render_start !== ~e.kind || swap !== e.kind || cyc != e.at || back_sel !== e.bs) begin
            n_bad++;
            $display("FAIL event got rs=%b swap=%b cyc=%0d bs=%b exp kind=%0d cyc=%0d bs=%b",
                     render_start, swap, cyc, back_sel, e.kind, e.at, e.bs);
          end
        end
      end
    end
  end

  task automatic at_cycle(input int n);
    if (cyc > n) begin
      n_cmp++; n_bad++; $display("FAIL schedule cyc=%0d target=%0d", cyc, n);
    end
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_then_enable(input int start_c, input int gap);
    for (int c = start_c; c < start_c + gap; c++) begin
      at_cycle(c);
      enable = 1'b0;
      frame_start = ($urandom % 3) == 0;
      render_done = ($urandom % 3) == 0;
    end
    at_cycle(start_c + gap);
    enable = 1'b1;
    frame_start = ($urandom % 2) == 0;
    render_done = ($urandom % 2) == 0;
    next_e = start_c + gap + 1;
  endtask

  // L=0 means the back buffer never reports clearing; k=0 means frame_start coincides with render_done.
  task automatic run_frame(input int L, input int d, input int k, input int n_drop,
                           input bit fs_clr, input bit en_swap, input int gap);
    int e_c, r_c, rd, fs, s_c, fsc, nrd, dr0, dr1, nd;
    e_c = next_e;
    r_c = (L == 0) ? e_c + T : e_c + L + 2;
    rd  = r_c + d;
    fs  = rd + k;
    s_c = fs + 1;
    for (int c = e_c; c <= r_c - 2; c++) exp_clr[c] = m_bs ? 2'b10 : 2'b01;
    for (int c = e_c; c <= s_c; c++) exp_busy[c] = 1'b1;
    if (L == 0 && err_from < 0) err_from = r_c;
    evq.push_back('{kind: 1'b0, at: r_c, bs: m_bs});
    evq.push_back('{kind: 1'b1, at: s_c, bs: m_bs});
    cl_len[m_bs] = L;
    never_clr[m_bs] = (L == 0);
    nd  = (n_drop > d) ? d : n_drop;
    dr0 = (nd >= 1) ? r_c : -1;
    dr1 = (nd >= 2) ? r_c + (d / 2) : -1;
    fsc = fs_clr ? e_c + int'($urandom_range(0, r_c - 1 - e_c)) : -1;
    nrd = (k >= 2) ? rd + 1 : -1;
    for (int c = e_c; c <= s_c; c++) begin
      at_cycle(c);
      frame_start = (c == fs) || (c == fsc) || (c == dr0) || (c == dr1);
      render_done = (c == rd) || (c == nrd);
      enable = (c == s_c) ? en_swap : (($urandom % 2) == 0);
    end
    m_bs = ~m_bs;
    if (en_swap) next_e = s_c + 1;
    else idle_then_enable(s_c + 1, gap);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e_c, kk;
    at_cycle(3);
    n_cmp++;
    if ({back_sel, busy, swap, render_start, fb0_clear, fb1_clear, clear_err} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_state got=%b exp=0000000",
               {back_sel, busy, swap, render_start, fb0_clear, fb1_clear, clear_err});
    end
    rst = 1'b0;
    idle_then_enable(3, 2);

    run_frame(FB_W*FB_H, 5, 3, 0, 1'b0, 1'b1, 0);
    run_frame(FB_W*FB_H, 3, 100, 0, 1'b0, 1'b1, 0);
    run_frame(20, 4, 0, 0, 1'b1, 1'b1, 0);
    run_frame(12, 10, 4, 2, 1'b0, 1'b1, 0);
    run_frame(0, 6, 2, 0, 1'b0, 1'b1, 0);
    run_frame(T - 3, 0, 1, 0, 1'b0, 1'b1, 0);
    run_frame(9, 7, 5, 1, 1'b1, 1'b0, 3);

    for (int i = 0; i < 30; i++) begin
      kk = (($urandom % 10) < 3) ? 0 : int'($urandom_range(1, 12));
      run_frame((($urandom % 8) == 0) ? 0 : int'($urandom_range(1, T - 3)),
                int'($urandom_range(0, 15)), kk, int'($urandom_range(0, 2)),
                ($urandom % 3) == 0, (i == 29) ? 1'b1 : (($urandom % 4) != 0),
                int'($urandom_range(0, 4)));
    end

    e_c = next_e;
    for (int c = e_c; c <= e_c + 3; c++) begin
      exp_clr[c] = m_bs ? 2'b10 : 2'b01;
      exp_busy[c] = 1'b1;
    end
    cl_len[m_bs] = FB_W*FB_H;
    never_clr[m_bs] = 1'b0;
    at_cycle(e_c);
    enable = 1'b0; frame_start = 1'b0; render_done = 1'b0;
    at_cycle(e_c + 3);
    rst = 1'b1;
    err_until = e_c + 4;
    at_cycle(e_c + 4);
    n_cmp++;
    if ({fb1_clear, fb0_clear, back_sel} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid_clear got clr=%b bs=%b exp clr=00 bs=0", {fb1_clear, fb0_clear}, back_sel);
    end
    rst = 1'b0;
    at_cycle(e_c + 12);
    n_cmp++;
    if (evq.size() != 0) begin
      n_bad++; $display("FAIL pending_events got=%0d exp=0", evq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
